tcp_recv_axis: RTL and testbench
================================

TCP_RECV_AXIS -- requirements
Module: tcp_recv_axis

Interface
REQ-001 SHALL have parameter MAX_OPT_WORDS, default 10, meaning the maximum accepted option words (1..10).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the statistics counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports s_tdata/s_tvalid/s_tlast (in, 32/1/1) and s_tready (out, 1): TCP segment input, one 32-bit big-endian word per beat, tlast on the final beat.
REQ-006 SHALL have outputs hdr_valid (1), src_port (16), dst_port (16), seq_num (32), ack_num (32), data_offset (4), flags (9), win_size (16), checksum (16), urg_ptr (16), carrying the parsed header.
REQ-007 SHALL have outputs opt_tdata (32), opt_tvalid (1), opt_tlast (1): the option words, with no backpressure.
REQ-008 SHALL have outputs pay_tdata (32), pay_tvalid (1), pay_tlast (1) and input pay_ready (1): the payload stream.
REQ-009 SHALL have outputs err_valid (1) and err_code (2): 01 = bad offset, 10 = truncated.
REQ-010 SHALL have outputs pkt_cnt and err_cnt, each CNT_W wide.

Function
REQ-011 SHALL use states HDR (word index 0..4), OPT, PAY and DROP.
REQ-012 SHALL set s_tready = pay_ready in PAY and s_tready = 1 in every other state; a beat is accepted when s_tvalid & s_tready.
REQ-013 SHALL capture header words in HDR as follows:
- w0: src_port=[31:16], dst_port=[15:0]
- w1: seq_num
- w2: ack_num
- w3: data_offset=[31:28], flags=[24:16], win_size=[15:0]
- w4: checksum=[31:16], urg_ptr=[15:0]
REQ-014 SHALL, on accepting w4, evaluate the offset captured at w3:
- offset < 5 or offset > 5+MAX_OPT_WORDS -> error 01, go to DROP (go to HDR instead if w4 carries tlast)
- offset > 5 -> go to OPT
- offset == 5 -> go to PAY, or to HDR if w4 carries tlast
REQ-015 SHALL, in OPT, register each accepted word to opt_tdata with opt_tvalid high for 1 cycle (1-cycle latency), and set opt_tlast on word number offset-5.
REQ-016 SHALL, after the last option word, go to PAY, or to HDR if that word carries tlast.
REQ-017 SHALL pulse hdr_valid for 1 cycle, one cycle after the last header/option word is accepted, with the fields stable until the next w0 is accepted.
REQ-018 SHALL, in PAY, drive the payload combinationally: pay_tdata = s_tdata, pay_tvalid = s_tvalid, pay_tlast = s_tlast.
REQ-019 SHALL return from PAY to HDR on an accepted tlast.
REQ-020 SHALL, when tlast arrives in HDR before w4 or in OPT before the last option word, raise error 10 and go to HDR.
REQ-021 SHALL, in DROP, discard beats until tlast, then go to HDR.
REQ-022 SHALL pulse err_valid for 1 cycle, one cycle after the offending beat, with err_code held until the next error.
REQ-023 SHALL not emit hdr_valid for an errored segment.
REQ-024 SHALL increment pkt_cnt once per segment that ends without error, and err_cnt once per error; both counters wrap at 2^CNT_W.
REQ-025 SHALL keep state and outputs unchanged (other than the 1-cycle pulses) in cycles where s_tvalid=0.

Reset
REQ-026 SHALL, on reset, clear all registered outputs, counters and pulses to 0 and set the state to HDR with word index 0.
REQ-027 SHALL abandon any segment in progress on reset, asserted mid-segment, with no error and no counting; the first beat accepted after reset is w0.

Configuration
REQ-028 SHALL, with macro TCP_RECV_CSUM_EN defined, add outputs csum_valid (1) and csum_sum (16).
REQ-029 SHALL, with TCP_RECV_CSUM_EN defined, compute csum_sum as the ones-complement end-around-carry sum of both 16-bit halves of every accepted beat of a non-errored segment (pseudo-header excluded), pulsing csum_valid one cycle after the tlast beat.
REQ-030 SHALL, without TCP_RECV_CSUM_EN, have neither these ports nor the adder logic.

Verification
REQ-031 SHALL cover: segment with offset 5 and 2 payload words 0xDEADBEEF, 0x01020304 (tlast) -> hdr_valid once; both words on pay_tdata in order, tlast on the second; pkt_cnt = 1.
REQ-032 SHALL cover: offset 7, options 0x020405B4 and 0x01010402, no payload (tlast on option 2) -> two opt_tvalid pulses, opt_tlast on the second, hdr_valid pulse, no pay_tvalid.
REQ-033 SHALL cover: offset 3, 3 more beats after w4 -> err_code 01, beats dropped, err_cnt = 1, no hdr_valid.
REQ-034 SHALL cover: tlast on w2 -> err_code 10; the next segment parses correctly.
REQ-035 SHALL cover: pay_ready low 3 cycles mid-payload -> s_tready low for those cycles, no data lost or duplicated.
REQ-036 SHALL cover: reset after w3 of a segment, then a clean segment -> fields match the clean segment, counters 0 then pkt_cnt = 1; with TCP_RECV_CSUM_EN defined, csum_sum equals a software ones-complement sum.

Source files
------------

// File: rtl/tcp_recv_axis.sv
// TCP segment receiver: header parse, option and payload split, error counting.
// Define TCP_RECV_CSUM_EN to add the running ones-complement checksum outputs.
module tcp_recv_axis #(
  parameter int MAX_OPT_WORDS = 10,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic             hdr_valid,
  output logic [15:0]      src_port,
  output logic [15:0]      dst_port,
  output logic [31:0]      seq_num,
  output logic [31:0]      ack_num,
  output logic [3:0]       data_offset,
  output logic [8:0]       flags,
  output logic [15:0]      win_size,
  output logic [15:0]      checksum,
  output logic [15:0]      urg_ptr,
  output logic [31:0]      opt_tdata,
  output logic             opt_tvalid,
  output logic             opt_tlast,
  output logic [31:0]      pay_tdata,
  output logic             pay_tvalid,
  output logic             pay_tlast,
  input  logic             pay_ready,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef TCP_RECV_CSUM_EN
  ,
  output logic             csum_valid,
  output logic [15:0]      csum_sum
`endif
);

  typedef enum logic [1:0] {
    HDR,
    OPT,
    PAY,
    DROP
  } state_t;

  localparam logic [4:0] OFF_MAX = 5'(5 + MAX_OPT_WORDS);

  state_t     state, state_nx;
  logic [2:0] idx, idx_nx;
  logic [3:0] opt_cnt, opt_cnt_nx;
  logic       acc;
  logic       off_bad;
  logic       opt_is_last;
  logic       hdr_pulse;
  logic       err_pulse;
  logic [1:0] err_nx;
  logic       opt_pulse;
  logic       opt_last;
  logic       ok_end;

  assign s_tready = (state == PAY) ? pay_ready : 1'b1;
  assign acc      = s_tvalid & s_tready;

  assign pay_tdata  = s_tdata;
  assign pay_tvalid = (state == PAY) & s_tvalid;
  assign pay_tlast  = (state == PAY) & s_tlast;

  assign off_bad = (data_offset < 4'd5) |
                   ({1'b0, data_offset} > OFF_MAX);
  assign opt_is_last =
    (opt_cnt + 4'd1) == (data_offset - 4'd5);

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    opt_cnt_nx = opt_cnt;
    hdr_pulse  = 1'b0;
    err_pulse  = 1'b0;
    err_nx     = err_code;
    opt_pulse  = 1'b0;
    opt_last   = 1'b0;
    ok_end     = 1'b0;
    unique case (state)
      HDR: begin
        if (acc) begin
          if (idx != 3'd4) begin
            if (s_tlast) begin
              err_pulse = 1'b1;
              err_nx    = 2'b10;
              idx_nx    = 3'd0;
            end else begin
              idx_nx = idx + 3'd1;
            end
          end else begin
            idx_nx = 3'd0;
            if (off_bad) begin
              err_pulse = 1'b1;
              err_nx    = 2'b01;
              state_nx  = s_tlast ? HDR : DROP;
            end else if (data_offset > 4'd5) begin
              // options announced but segment already over
              if (s_tlast) begin
                err_pulse = 1'b1;
                err_nx    = 2'b10;
              end else begin
                state_nx   = OPT;
                opt_cnt_nx = 4'd0;
              end
            end else begin
              hdr_pulse = 1'b1;
              if (s_tlast) ok_end = 1'b1;
              else state_nx = PAY;
            end
          end
        end
      end
      OPT: begin
        if (acc) begin
          opt_pulse  = 1'b1;
          opt_cnt_nx = opt_cnt + 4'd1;
          if (opt_is_last) begin
            opt_last  = 1'b1;
            hdr_pulse = 1'b1;
            if (s_tlast) begin
              ok_end   = 1'b1;
              state_nx = HDR;
            end else begin
              state_nx = PAY;
            end
          end else if (s_tlast) begin
            err_pulse = 1'b1;
            err_nx    = 2'b10;
            state_nx  = HDR;
          end
        end
      end
      PAY: begin
        if (acc && s_tlast) begin
          ok_end   = 1'b1;
          state_nx = HDR;
        end
      end
      DROP: begin
        if (acc && s_tlast) state_nx = HDR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HDR;
      idx         <= 3'd0;
      opt_cnt     <= 4'd0;
      hdr_valid   <= 1'b0;
      src_port    <= '0;
      dst_port    <= '0;
      seq_num     <= '0;
      ack_num     <= '0;
      data_offset <= '0;
      flags       <= '0;
      win_size    <= '0;
      checksum    <= '0;
      urg_ptr     <= '0;
      opt_tdata   <= '0;
      opt_tvalid  <= 1'b0;
      opt_tlast   <= 1'b0;
      err_valid   <= 1'b0;
      err_code    <= 2'b00;
      pkt_cnt     <= '0;
      err_cnt     <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      opt_cnt    <= opt_cnt_nx;
      hdr_valid  <= hdr_pulse;
      err_valid  <= err_pulse;
      opt_tvalid <= opt_pulse;
      opt_tlast  <= opt_last;
      if (opt_pulse) opt_tdata <= s_tdata;
      if (err_pulse) err_code <= err_nx;
      pkt_cnt <= pkt_cnt + {{(CNT_W-1){1'b0}}, ok_end};
      err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, err_pulse};
      if (state == HDR && acc) begin
        unique case (idx)
          3'd0: begin
            src_port <= s_tdata[31:16];
            dst_port <= s_tdata[15:0];
          end
          3'd1: seq_num <= s_tdata;
          3'd2: ack_num <= s_tdata;
          3'd3: begin
            data_offset <= s_tdata[31:28];
            flags       <= s_tdata[24:16];
            win_size    <= s_tdata[15:0];
          end
          3'd4: begin
            checksum <= s_tdata[31:16];
            urg_ptr  <= s_tdata[15:0];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TCP_RECV_CSUM_EN
  logic [15:0] csum_acc;
  logic [15:0] csum_base;
  logic [17:0] csum_raw;
  logic [16:0] csum_f1;
  logic [15:0] csum_next;

  // restart the sum on the first header word of every segment
  always_comb begin
    csum_base = (state == HDR && idx == 3'd0) ? 16'd0 : csum_acc;
    csum_raw  = {2'b00, csum_base} +
                {2'b00, s_tdata[31:16]} +
                {2'b00, s_tdata[15:0]};
    csum_f1   = {1'b0, csum_raw[15:0]} + {15'd0, csum_raw[17:16]};
    csum_next = csum_f1[15:0] + {15'd0, csum_f1[16]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_acc   <= '0;
      csum_valid <= 1'b0;
      csum_sum   <= '0;
    end else begin
      csum_valid <= ok_end;
      if (acc) csum_acc <= csum_next;
      if (ok_end) csum_sum <= csum_next;
    end
  end
`endif

endmodule

// File: tb/tb_tcp_recv_axis.sv
// Randomized bench for tcp_recv_axis against a segment-level reference model.
// Checksum outputs are checked when TCP_RECV_CSUM_EN is defined.
module tb_tcp_recv_axis;

  localparam int MAXO  = 10;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      s_tdata;
  logic             s_tvalid;
  logic             s_tlast;
  logic             s_tready;
  logic             hdr_valid;
  logic [15:0]      src_port, dst_port;
  logic [31:0]      seq_num, ack_num;
  logic [3:0]       data_offset;
  logic [8:0]       flags;
  logic [15:0]      win_size, checksum, urg_ptr;
  logic [31:0]      opt_tdata;
  logic             opt_tvalid, opt_tlast;
  logic [31:0]      pay_tdata;
  logic             pay_tvalid, pay_tlast;
  logic             pay_ready;
  logic             err_valid;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] pkt_cnt, err_cnt;
`ifdef TCP_RECV_CSUM_EN
  logic             csum_valid;
  logic [15:0]      csum_sum;
`endif

  tcp_recv_axis #(.MAX_OPT_WORDS(MAXO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready),
    .hdr_valid(hdr_valid),
    .src_port(src_port), .dst_port(dst_port),
    .seq_num(seq_num), .ack_num(ack_num),
    .data_offset(data_offset), .flags(flags),
    .win_size(win_size), .checksum(checksum),
    .urg_ptr(urg_ptr),
    .opt_tdata(opt_tdata), .opt_tvalid(opt_tvalid),
    .opt_tlast(opt_tlast),
    .pay_tdata(pay_tdata), .pay_tvalid(pay_tvalid),
    .pay_tlast(pay_tlast), .pay_ready(pay_ready),
    .err_valid(err_valid), .err_code(err_code),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
`ifdef TCP_RECV_CSUM_EN
    ,
    .csum_valid(csum_valid), .csum_sum(csum_sum)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [32:0] q_opt[$];
  logic [32:0] q_pay[$];
  logic [1:0]  q_err[$];
  logic [31:0] q_hdr[$];
  logic [15:0] q_csum[$];
  logic [31:0] seg[$];
  int          m_pkt;
  int          m_err;
  int          pay_start;
  int          low_left;
  bit          rnd_mode;
  bit          mon_en;

  // expected outputs of one whole segment, from the protocol rules
  task automatic model_seg();
    int n;
    int off;
    int nopt;
    longint s;
    n = seg.size();
    pay_start = 1000;
    if (n < 5) begin
      q_err.push_back(2'b10);
      m_err++;
      return;
    end
    off = int'(seg[3][31:28]);
    if (off < 5 || off > 5 + MAXO) begin
      q_err.push_back(2'b01);
      m_err++;
      return;
    end
    nopt = off - 5;
    if (n - 5 < nopt) begin
      for (int i = 5; i < n; i++) q_opt.push_back({1'b0, seg[i]});
      q_err.push_back(2'b10);
      m_err++;
      return;
    end
    for (int i = 0; i < nopt; i++)
      q_opt.push_back({i == nopt - 1, seg[5 + i]});
    for (int i = 0; i < 5; i++) q_hdr.push_back(seg[i]);
    pay_start = 5 + nopt;
    for (int i = 5 + nopt; i < n; i++)
      q_pay.push_back({i == n - 1, seg[i]});
    m_pkt++;
    s = 0;
    for (int i = 0; i < n; i++)
      s += longint'(seg[i][31:16]) + longint'(seg[i][15:0]);
    while (s > 64'hFFFF) s = (s & 64'hFFFF) + (s >> 16);
    q_csum.push_back(16'(s));
  endtask

  logic [32:0] e;
  logic [31:0] h0, h1, h2, h3, h4;

  always @(negedge clk) begin
    if (mon_en) begin
      if (opt_tvalid) begin
        if (q_opt.size() == 0) chk("opt_unexpected", 1, 0);
        else begin
          e = q_opt.pop_front();
          chk("opt_tdata", opt_tdata, e[31:0]);
          chk("opt_tlast", opt_tlast, e[32]);
        end
      end
      if (pay_tvalid && pay_ready) begin
        if (q_pay.size() == 0) chk("pay_unexpected", 1, 0);
        else begin
          e = q_pay.pop_front();
          chk("pay_tdata", pay_tdata, e[31:0]);
          chk("pay_tlast", pay_tlast, e[32]);
        end
      end
      if (hdr_valid) begin
        if (q_hdr.size() < 5) chk("hdr_unexpected", 1, 0);
        else begin
          h0 = q_hdr.pop_front();
          h1 = q_hdr.pop_front();
          h2 = q_hdr.pop_front();
          h3 = q_hdr.pop_front();
          h4 = q_hdr.pop_front();
          chk("src_port", src_port, h0[31:16]);
          chk("dst_port", dst_port, h0[15:0]);
          chk("seq_num", seq_num, h1);
          chk("ack_num", ack_num, h2);
          chk("data_offset", data_offset, h3[31:28]);
          chk("flags", flags, h3[24:16]);
          chk("win_size", win_size, h3[15:0]);
          chk("checksum", checksum, h4[31:16]);
          chk("urg_ptr", urg_ptr, h4[15:0]);
        end
      end
      if (err_valid) begin
        if (q_err.size() == 0) chk("err_unexpected", 1, 0);
        else chk("err_code", err_code, q_err.pop_front());
      end
`ifdef TCP_RECV_CSUM_EN
      if (csum_valid) begin
        if (q_csum.size() == 0) chk("csum_unexpected", 1, 0);
        else chk("csum_sum", csum_sum, q_csum.pop_front());
      end
`endif
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic put_beat(input logic [31:0] d,
                          input logic l,
                          input bit is_pay);
    int  stall;
    bit  done;
    stall = 0;
    done  = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      if (is_pay && low_left > 0) begin
        pay_ready = 1'b0;
        low_left--;
      end else if (rnd_mode && stall < 3)
        pay_ready = ($urandom_range(0, 3) != 0);
      else
        pay_ready = 1'b1;
      @(negedge clk);
      chk("s_tready", s_tready, is_pay ? pay_ready : 1'b1);
      if (s_tready) done = 1;
      else begin
        stall++;
        if (stall > 20) begin
          chk("tready_timeout", 0, 1);
          done = 1;
        end
      end
    end
  endtask

  task automatic send_seg(input int stall_at);
    int n;
    n = seg.size();
    model_seg();
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) low_left = 3;
      put_beat(seg[i], i == n - 1, i >= pay_start);
      if (rnd_mode && $urandom_range(0, 3) == 0) idle();
    end
    repeat (3) idle();
    chk("pkt_cnt", pkt_cnt, CNT_W'(m_pkt));
    chk("err_cnt", err_cnt, CNT_W'(m_err));
    chk("opt_left", q_opt.size(), 0);
    chk("pay_left", q_pay.size(), 0);
    chk("hdr_left", q_hdr.size(), 0);
    chk("err_left", q_err.size(), 0);
`ifdef TCP_RECV_CSUM_EN
    chk("csum_left", q_csum.size(), 0);
`endif
    q_csum.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_pkt = 0;
    m_err = 0;
  endtask

  task automatic hdr5(input logic [3:0] off);
    logic [31:0] w3;
    w3 = $urandom();
    w3[31:28] = off;
    seg.delete();
    seg.push_back($urandom());
    seg.push_back($urandom());
    seg.push_back($urandom());
    seg.push_back(w3);
    seg.push_back($urandom());
  endtask

  task automatic gen_seg();
    int r, off, nopt, npay, n;
    r = $urandom_range(0, 9);
    if (r < 2) off = $urandom_range(0, 4);
    else if (r < 5) off = 5;
    else off = $urandom_range(6, 15);
    hdr5(4'(off));
    nopt = (off > 5) ? off - 5 : 0;
    npay = $urandom_range(0, 4);
    n = (off < 5) ? 5 + $urandom_range(0, 3) : 5 + nopt + npay;
    if ($urandom_range(0, 5) == 0) n = $urandom_range(1, n);
    while (seg.size() > n) void'(seg.pop_back());
    while (seg.size() < n) seg.push_back($urandom());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    s_tdata   = '0;
    pay_ready = 1'b1;
    low_left  = 0;
    rnd_mode  = 0;
    mon_en    = 0;
    m_pkt     = 0;
    m_err     = 0;
    do_reset();
    @(negedge clk);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_opt_tvalid", opt_tvalid, 0);
    chk("rst_pay_tvalid", pay_tvalid, 0);
    chk("rst_src_port", src_port, 0);
    chk("rst_seq_num", seq_num, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_s_tready", s_tready, 1);
`ifdef TCP_RECV_CSUM_EN
    chk("rst_csum_valid", csum_valid, 0);
    chk("rst_csum_sum", csum_sum, 0);
`endif
    mon_en = 1;

    hdr5(4'd5);
    seg.push_back(32'hDEADBEEF);
    seg.push_back(32'h01020304);
    send_seg(-1);

    hdr5(4'd7);
    seg.push_back(32'h020405B4);
    seg.push_back(32'h01010402);
    send_seg(-1);

    hdr5(4'd3);
    repeat (3) seg.push_back($urandom());
    send_seg(-1);

    hdr5(4'd5);
    while (seg.size() > 3) void'(seg.pop_back());
    send_seg(-1);
    hdr5(4'd6);
    seg.push_back($urandom());
    seg.push_back($urandom());
    send_seg(-1);

    hdr5(4'd5);
    repeat (5) seg.push_back($urandom());
    send_seg(6);

    hdr5(4'd5);
    for (int i = 0; i < 4; i++) put_beat(seg[i], 1'b0, 0);
    do_reset();
    @(negedge clk);
    chk("mid_rst_pkt_cnt", pkt_cnt, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    hdr5(4'd5);
    seg.push_back($urandom());
    seg.push_back($urandom());
    send_seg(-1);
    chk("post_rst_pkt_one", pkt_cnt, 1);

    rnd_mode = 1;
    for (int k = 0; k < 200; k++) begin
      gen_seg();
      send_seg(-1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
